// File: rtl/exec_branch_ras_pkg.sv
// Shared widths, flag indices, select/condition encodings and the 3-from-8 select helper
// for the branch execution unit.
package exec_branch_ras_pkg;

    localparam int ADDR    = 16;
    localparam int W_CC    = 3;
    localparam int W_FLAGS = 4;

    localparam int F_ZERO = 0;
    localparam int F_SIGN = 1;
    localparam int F_CRRY = 2;
    localparam int F_OVRF = 3;

    // Non-conditional select encodings; 6 and 7 hand control to cc_i
    localparam logic [2:0] SEL_ALW = 3'd0;
    localparam logic [2:0] SEL_Z   = 3'd1;
    localparam logic [2:0] SEL_NZ  = 3'd2;
    localparam logic [2:0] SEL_NCZ = 3'd3;
    localparam logic [2:0] SEL_C   = 3'd4;
    localparam logic [2:0] SEL_NEV = 3'd5;
    localparam logic [2:0] SEL_REL = 3'd7;

    localparam logic [2:0] CC_ALW = 3'd0;
    localparam logic [2:0] CC_Z   = 3'd1;
    localparam logic [2:0] CC_NS  = 3'd2;
    localparam logic [2:0] CC_S   = 3'd3;
    localparam logic [2:0] CC_C   = 3'd4;
    localparam logic [2:0] CC_V   = 3'd5;

    function automatic logic sel_3of8(input logic [7:0] vec, input logic [2:0] idx);
        return vec[idx];
    endfunction

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack: overwrites the oldest entry when full and
// reports overflow/underflow combinationally for the caller to register.
module branch_ras #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             err_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] top_idx_s;

    assign top_idx_s = ptr_r - PTR_W'(1);
    assign top_o     = mem_r[top_idx_s];
    assign empty_o   = (count_r == CNT_W'(0));
    assign full_o    = (count_r == CNT_W'(DEPTH));
    assign err_o     = (pop_i & empty_o) | (push_i & ~pop_i & full_o);

    // Stack state: ptr_r names the next free slot, so the top sits just below it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r   <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    mem_r[ptr_r] <= push_data_i;
                    ptr_r        <= ptr_r + PTR_W'(1);
                    if (!full_o) begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (!empty_o) begin
                        ptr_r   <= top_idx_s;
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                2'b11: begin
                    // Pop then push: replace the top in place; on empty the pop is a no-op
                    if (!empty_o) begin
                        mem_r[top_idx_s] <= push_data_i;
                    end else begin
                        mem_r[ptr_r] <= push_data_i;
                        ptr_r        <= ptr_r + PTR_W'(1);
                        count_r      <= CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/exec_branch_ras.sv
// Execute-stage branch unit: resolves taken/target, maintains the return-address
// stack for call/return and presents a registered result behind valid/ready.
module exec_branch_ras
    import exec_branch_ras_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int LINK_INC  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               brf_i,
    input  logic               call_i,
    input  logic               ret_i,
    input  logic [W_CC-1:0]    cc_i,
    input  logic [2:0]         select_i,
    input  logic [W_FLAGS-1:0] flags_i,
    input  logic [ADDR-1:0]    opr1_i,
    input  logic [ADDR-1:0]    pc_i,
    input  logic               flush_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               branch_o,
    output logic [ADDR-1:0]    branch_addr_o,
    output logic               ras_empty_o,
    output logic               ras_full_o,
    output logic               ras_err_o
);
    logic            valid_r, branch_r, err_r;
    logic [ADDR-1:0] addr_r;
    logic            accept_s, cond_en_s, taken_s, take_s, push_s, pop_s;
    logic            ras_err_s, ras_empty_s, ras_full_s;
    logic [7:0]      cc_vec_s, sel_vec_s;
    logic [ADDR-1:0] target_s, link_s, ras_top_s;

    assign ready_o   = ~valid_r | ready_i;
    assign accept_s  = valid_i & ready_o & ~flush_i;
    assign cond_en_s = select_i[2] & select_i[1];
    assign take_s    = brf_i & taken_s;
    assign push_s    = accept_s & take_s & call_i;
    assign pop_s     = accept_s & take_s & ret_i;
    assign link_s    = pc_i + ADDR'(LINK_INC);

    // Condition resolution and target selection
    always_comb begin
        cc_vec_s          = 8'h00;
        cc_vec_s[CC_ALW]  = 1'b1;
        cc_vec_s[CC_Z]    = flags_i[F_ZERO];
        cc_vec_s[CC_NS]   = ~flags_i[F_SIGN];
        cc_vec_s[CC_S]    = flags_i[F_SIGN];
        cc_vec_s[CC_C]    = flags_i[F_CRRY];
        cc_vec_s[CC_V]    = flags_i[F_OVRF];
        sel_vec_s         = 8'h00;
        sel_vec_s[SEL_ALW] = 1'b1;
        sel_vec_s[SEL_Z]   = flags_i[F_ZERO];
        sel_vec_s[SEL_NZ]  = ~flags_i[F_ZERO];
        sel_vec_s[SEL_NCZ] = ~(flags_i[F_CRRY] | flags_i[F_ZERO]);
        sel_vec_s[SEL_C]   = flags_i[F_CRRY];
        sel_vec_s[SEL_NEV] = 1'b0;
        if (cond_en_s) begin
            taken_s = sel_3of8(cc_vec_s, cc_i);
        end else begin
            taken_s = sel_3of8(sel_vec_s, select_i);
        end
        if (ret_i && !ras_empty_s) begin
            target_s = ras_top_s;
        end else if (select_i == SEL_REL) begin
            target_s = pc_i + opr1_i;
        end else begin
            target_s = opr1_i;
        end
    end

    branch_ras #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .push_data_i (link_s),
        .top_o       (ras_top_s),
        .empty_o     (ras_empty_s),
        .full_o      (ras_full_s),
        .err_o       (ras_err_s)
    );

    // Result register: load on accept, hold while stalled, flush drops the held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= 1'b0;
            branch_r <= 1'b0;
            addr_r   <= '0;
            err_r    <= 1'b0;
        end else if (flush_i) begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else if (ready_o) begin
            valid_r <= valid_i;
            err_r   <= ras_err_s;
            if (accept_s) begin
                branch_r <= take_s;
                addr_r   <= target_s;
            end
        end
    end

    assign valid_o       = valid_r;
    assign branch_o      = branch_r;
    assign branch_addr_o = addr_r;
    assign ras_err_o     = err_r;
    assign ras_empty_o   = ras_empty_s;
    assign ras_full_o    = ras_full_s;

endmodule
